// File: rtl/move_queue_if.sv
// ----------------------------------------------------------------------------
// move_queue_if
//
// Purpose:
//   Bundles every handshake and status signal of the move queue into one
//   interface. There are two sides: the producer/stepper side (master) and
//   the queue itself (slave).
//
// Parameters:
//   DEPTH      - number of queue entries (power of two, >= 2*WORD_MOVES)
//   WORD_MOVES - move slots carried by one push word
//
// Signals (direction seen from the queue, i.e. the slave modport):
//   push_valid  in   push request
//   push_moves  in   packed 4-bit move codes, slot 0 in bits [3:0]
//   push_count  in   number of valid slots, counted from slot 0 upward
//   push_ready  out  enough free room for a full push word
//   run         in   level enable for dispatch
//   flush       in   pulse that discards every queued entry
//   next_move   out  code of the move being issued or in flight
//   move_start  out  one-cycle start pulse to the stepper driver
//   move_done   in   stepper driver status, high while idle
//   count       out  occupied entries
//   executed    out  moves issued since reset, wraps at 8 bits
//   seq_done    out  one-cycle pulse when dispatch drains the queue
//   overflow    out  sticky flag for a push made while push_ready was low
// ----------------------------------------------------------------------------
interface move_queue_if #(
  parameter int DEPTH      = 64,
  parameter int WORD_MOVES = 8
);
  localparam int PCW = $clog2(WORD_MOVES + 1);
  localparam int CW  = $clog2(DEPTH + 1);

  logic                    push_valid;
  logic [4*WORD_MOVES-1:0] push_moves;
  logic [PCW-1:0]          push_count;
  logic                    push_ready;
  logic                    run;
  logic                    flush;
  logic [3:0]              next_move;
  logic                    move_start;
  logic                    move_done;
  logic [CW-1:0]           count;
  logic [7:0]              executed;
  logic                    seq_done;
  logic                    overflow;

  // Producer and stepper side: drives pushes, run/flush and the driver status.
  modport master (
    output push_valid, push_moves, push_count, run, flush, move_done,
    input  push_ready, next_move, move_start, count, executed, seq_done,
           overflow
  );

  // Queue side.
  modport slave (
    input  push_valid, push_moves, push_count, run, flush, move_done,
    output push_ready, next_move, move_start, count, executed, seq_done,
           overflow
  );
endinterface

// File: rtl/move_queue.sv
// ----------------------------------------------------------------------------
// move_queue
//
// Purpose:
//   Streaming move FIFO and dispatcher that sits in front of the stepper
//   driver. Packed words of 4-bit face-turn codes are written into a circular
//   buffer. They are then issued one at a time through a start/done handshake.
//   Codes outside 2..13 are stored but dropped at dispatch, at one cycle each.
//
// Optional feature:
//   MOVE_QUEUE_CANCEL_EN - when defined, a valid move immediately followed by
//   its inverse (same bits [3:1], different bit 0) is removed from the head
//   in one cycle. Neither move is issued. When undefined, every valid code is
//   issued.
//
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-low; low clears all state
//   bus    - move_queue_if.slave (push handshake, run/flush, stepper
//            handshake, status outputs)
// ----------------------------------------------------------------------------
module move_queue #(
  parameter int DEPTH      = 64,
  parameter int WORD_MOVES = 8
) (
  input  logic        clock,
  input  logic        reset,
  move_queue_if.slave bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PCW = $clog2(WORD_MOVES + 1);

  // push_ready means at least WORD_MOVES entries are free.
  localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH - WORD_MOVES);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [3:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic          r_pushReady;
  logic          r_overflow;
  logic [1:0]    r_state;
  logic [3:0]    r_nextMove;
  logic          r_moveStart;
  logic [7:0]    r_executed;
  logic          r_seqDone;
  // Set once a move has been issued. Cleared by seq_done or flush, so a
  // drain pulse is only reported for a sequence that really ran.
  logic          r_issuedSince;

  logic [3:0]    w_head;
  logic          w_pushAccept;
  logic          w_pushReject;
  logic [CW-1:0] w_pushAmount;
  logic          w_canDispatch;
  logic          w_cancel;
  logic          w_skip;
  logic          w_start;
  logic [1:0]    w_popAmount;
  logic [CW-1:0] w_countNext;
  logic [1:0]    w_stateNext;
  logic          w_seqDoneNext;
  logic          w_issuedNext;

  function automatic logic isValid(input logic [3:0] code);
    return (code >= 4'd2) && (code <= 4'd13);
  endfunction

  // Push acceptance. Flush has priority, so a push in the flush cycle is
  // dropped and does not count as an overflow either.
  always_comb begin
    w_pushAccept = bus.push_valid & r_pushReady & ~bus.flush;
    w_pushReject = bus.push_valid & ~r_pushReady & ~bus.flush;
    w_pushAmount = w_pushAccept ? CW'(bus.push_count) : '0;
  end

  // Head inspection in IDLE: cancellation pair first, then invalid-code skip,
  // and otherwise start a real move. Nothing is decided while flushing, so
  // a move is never started from an entry that is being discarded.
  always_comb begin
    w_head        = r_mem[r_rdPtr];
    w_canDispatch = (r_state == IDLE) && bus.run && (r_count != '0) &&
                    !bus.flush;
  end

`ifdef MOVE_QUEUE_CANCEL_EN
  logic [3:0] w_head2;

  // A move and its inverse at the head cancel out.
  always_comb begin
    w_head2  = r_mem[r_rdPtr + PW'(1)];
    w_cancel = w_canDispatch && (r_count >= CW'(2)) &&
               isValid(w_head) && isValid(w_head2) &&
               (w_head[3:1] == w_head2[3:1]) && (w_head[0] != w_head2[0]);
  end
`else
  always_comb begin
    w_cancel = 1'b0;
  end
`endif

  always_comb begin
    w_skip  = w_canDispatch && !w_cancel && !isValid(w_head);
    w_start = w_canDispatch && !w_cancel && isValid(w_head);
  end

  // Pop bookkeeping. The issued move leaves the buffer during ISSUE. If a
  // flush lands in that cycle, the buffer is already being emptied and the
  // pop is dropped.
  always_comb begin
    w_popAmount = 2'd0;
    if (w_cancel) begin
      w_popAmount = 2'd2;
    end else if (w_skip) begin
      w_popAmount = 2'd1;
    end else if ((r_state == ISSUE) && !bus.flush) begin
      w_popAmount = 2'd1;
    end

    if (bus.flush) begin
      w_countNext = '0;
    end else begin
      w_countNext = r_count + w_pushAmount - CW'(w_popAmount);
    end
  end

  // Dispatch FSM. Once a move is started it always runs through both wait
  // states, even across a flush or a drop of run.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:      if (w_start)       w_stateNext = ISSUE;
      ISSUE:                        w_stateNext = WAIT_BUSY;
      WAIT_BUSY: if (!bus.move_done) w_stateNext = WAIT_DONE;
      WAIT_DONE: if (bus.move_done)  w_stateNext = IDLE;
      default:                      w_stateNext = IDLE;
    endcase
  end

  // Drain detection. A drain is reported when a finished move or an invalid
  // skip leaves the queue empty. A cancellation that empties the queue is
  // not a drain by itself.
  always_comb begin
    w_seqDoneNext = r_issuedSince && !bus.flush && (w_countNext == '0) &&
                    (((r_state == WAIT_DONE) && bus.move_done) || w_skip);

    w_issuedNext = r_issuedSince;
    if (bus.flush) begin
      w_issuedNext = 1'b0;
    end else if (w_seqDoneNext) begin
      w_issuedNext = 1'b0;
    end else if (r_state == ISSUE) begin
      w_issuedNext = 1'b1;
    end
  end

  // Storage array. It needs no reset: with count at zero no entry is ever
  // read before it has been written again.
  always_ff @(posedge clock) begin
    if (w_pushAccept) begin
      for (int i = 0; i < WORD_MOVES; i++) begin
        if (PCW'(i) < bus.push_count) begin
          r_mem[r_wrPtr + PW'(i)] <= bus.push_moves[4*i +: 4];
        end
      end
    end
  end

  // Pointers, occupancy and push status. Flush aligns the read pointer to
  // the write pointer, which empties the ring without touching the storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_count     <= '0;
      r_pushReady <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_rdPtr <= r_wrPtr;
      end else begin
        r_rdPtr <= r_rdPtr + PW'(w_popAmount);
      end
      if (w_pushAccept) begin
        r_wrPtr <= r_wrPtr + PW'(bus.push_count);
      end
      r_count     <= w_countNext;
      r_pushReady <= (w_countNext <= READY_LIMIT);
      if (w_pushReject) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FSM state and registered dispatch outputs. next_move is captured when
  // ISSUE is entered and holds until the next issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_nextMove    <= 4'd0;
      r_moveStart   <= 1'b0;
      r_executed    <= 8'd0;
      r_seqDone     <= 1'b0;
      r_issuedSince <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_moveStart   <= w_start;
      r_seqDone     <= w_seqDoneNext;
      r_issuedSince <= w_issuedNext;
      if (w_start) begin
        r_nextMove <= w_head;
      end
      if (r_state == ISSUE) begin
        r_executed <= r_executed + 8'd1;
      end
    end
  end

  assign bus.push_ready = r_pushReady;
  assign bus.next_move  = r_nextMove;
  assign bus.move_start = r_moveStart;
  assign bus.count      = r_count;
  assign bus.executed   = r_executed;
  assign bus.seq_done   = r_seqDone;
  assign bus.overflow   = r_overflow;
endmodule

// File: doc/move_queue.md
# move_queue

Parametrised move FIFO and dispatcher that sits between the solving logic and the `move_to_step` stepper driver. It accepts packed words of 4-bit face-turn codes and stores them in a circular buffer of configurable depth. It then issues them one at a time to the stepper driver using a start/done handshake. It replaces the fixed 200-bit sequencer with a streaming queue, and adds back-pressure, flush, invalid-code skipping and optional inverse-pair cancellation.

## Interface
- `DEPTH`, 64: queue entries; power of two, at least 2*`WORD_MOVES`.
- `WORD_MOVES`, 8: move slots per push word.
- `clock` input 1: system clock (25 MHz domain).
- `reset` input 1: asynchronous, active-low. Low clears all state immediately.
- `push_valid` input 1: push request.
- `push_moves` input 4*`WORD_MOVES`: packed moves. Slot i is bits [4i+3:4i]; slot 0 is executed first.
- `push_count` input clog2(`WORD_MOVES`+1): number of valid slots (0..`WORD_MOVES`), taken from slot 0 upward.
- `push_ready` output 1: high when free entries ≥ `WORD_MOVES`.
- `run` input 1: level signal; dispatch is allowed while high.
- `flush` input 1: pulse that discards all queued entries.
- `next_move` output 4: code of the move being issued or in flight.
- `move_start` output 1: one-cycle start pulse to the stepper driver.
- `move_done` input 1: stepper driver status, high while idle.
- `count` output clog2(`DEPTH`+1): occupied entries.
- `executed` output 8: moves issued since reset; wraps 255→0.
- `seq_done` output 1: one-cycle pulse when dispatch drains the queue.
- `overflow` output 1: sticky; set by a push made while `push_ready` is low.

## Operation
- Valid codes are 2–13: R, Ri, U, Ui, F, Fi, L, Li, B, Bi, D, Di. Codes 0, 1, 14 and 15 are stored but skipped at dispatch. Each skipped code costs one cycle, pops its entry, and does not increment `executed`.
- Accepted push (`push_valid` & `push_ready`): writes `push_count` entries at the write pointer. The pointer advances by `push_count` modulo `DEPTH`.
- Rejected push: entries are dropped and `overflow` is set to 1. `overflow` clears only on reset.
- The FSM has four states:
  - IDLE: if `run` and `count`>0, inspect the head entry. If it is invalid, pop it and stay in IDLE. If it is valid, go to ISSUE.
  - ISSUE: drive `next_move`=head, pulse `move_start`, pop the head, increment `executed`, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for `move_done`=0, meaning the driver has accepted the move, then go to WAIT_DONE.
  - WAIT_DONE: wait for `move_done`=1, then go to IDLE.
- `seq_done` pulses on the cycle the FSM enters IDLE from WAIT_DONE or from an invalid-code pop with `count`=0. It pulses only if at least one move was issued since the last `seq_done` or reset.
- `flush`: the buffer empties and both pointers align on the next cycle. The FSM never abandons an in-flight move: WAIT_BUSY and WAIT_DONE run to completion. `seq_done` is suppressed for that completion.
- Push and flush in the same cycle: flush wins and the push is discarded without setting `overflow`.
- Push and pop in the same cycle: both take effect. `count` = `count` + `push_count` − 1.
- `run` dropping mid-move: the current move completes and no further move is issued.

## Timing
- All outputs reset to 0: `next_move`, `move_start`, `count`, `executed`, `seq_done`, `overflow`, `push_ready`.
- `push_ready` is 1 in the first cycle after `reset` deasserts.
- Push-to-start latency on an empty queue with `run` high: `move_start` asserts 2 cycles after the push cycle (write, IDLE, ISSUE).
- Back-to-back moves: start of move N+1 is 2 cycles after `move_done` rises for move N.
- `push_ready` and `count` are registered and reflect the previous cycle's push and pop.
- `next_move` holds its value from ISSUE until the next ISSUE.

## Configuration
- `MOVE_QUEUE_CANCEL_EN` defined:
  - In IDLE, if `count`≥2 and the two head entries are valid codes with equal [3:1] and differing bit 0 (X followed by Xi, or Xi followed by X), both entries are popped in one cycle with no `move_start` and no change to `executed`.
  - Cancellation is checked before the single-entry path.
  - A cancellation that empties the queue does not by itself pulse `seq_done`.
- Undefined: no cancellation; every valid code is issued.

## Test plan
- Reset low mid-WAIT_DONE with `count`=5 → on release, all outputs are 0, `push_ready`=1, and no `move_start` for 10 cycles with `run`=1.
- Push {R,U}, i.e. `push_moves` low byte 0x42 with `push_count`=2, `run`=1, and a stepper model that drops `move_done` for 20 cycles → `move_start` with `next_move`=2, then `next_move`=4, `executed`=2, one `seq_done` pulse.
- Push 8 words of 8 moves with `DEPTH`=64, `run`=0 → `count`=64, `push_ready`=0. A 9th push sets `overflow`=1 and `count` stays 64.
- Push {0,0,F} with `push_count`=3 → exactly one `move_start` (`next_move`=6); `executed`=1.
- `flush` during WAIT_BUSY with `count`=10 → `count`=0 next cycle, the current move finishes, no `seq_done`, no further starts.
- With `MOVE_QUEUE_CANCEL_EN`: push {R,Ri,U} → only U is issued, `executed`=1. Without the macro: three starts, `executed`=3.
